// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Holds the size codes, the FSM state type and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  function automatic logic bad_req(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/subword_align.sv
// Lane merge for sub-word stores and lane extract/extend for loads.
// Purely combinational; byte lane = off, half lane = off[1].
module subword_align
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] word,
  input  logic [DW-1:0] data,
  input  logic [1:0]    size,
  input  logic [1:0]    off,
  input  logic          uns,
  output logic [DW-1:0] merged,
  output logic [DW-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{off, 3'b000} +: 8];
  assign h = word[{off[1], 4'b0000} +: 16];

  always_comb begin
    merged = word;
    ext    = '0;
    unique case (size)
      SZ_B: begin
        merged[{off, 3'b000} +: 8] = data[7:0];
        ext = {{24{~uns & b[7]}}, b};
      end
      SZ_H: begin
        merged[{off[1], 4'b0000} +: 16] = data[15:0];
        ext = {{16{~uns & h[15]}}, h};
      end
      SZ_W: begin
        merged = data;
        ext    = word;
      end
      SZ_X: begin
        merged = word;
        ext    = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-only data memory.
// Sub-word stores go through a read-modify-write of the full word.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic          uns_q;
  logic          err_q;

  logic          accept;
  logic          bad;
  logic [DW-1:0] merged;
  logic [DW-1:0] ext;

  assign accept = req_valid && req_ready;
  assign bad    = bad_req(req_size, req_addr[1:0]);

  subword_align #(.DW(DW)) u_align (
    .word   (mem_rd),
    .data   (wdata_q),
    .size   (size_q),
    .off    (addr_q[1:0]),
    .uns    (uns_q),
    .merged (merged),
    .ext    (ext)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_we    = (state_q == WRITE);
  assign mem_a     = {addr_q[AW-1:2], 2'b00};
  assign mem_wd    = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            err_q   <= bad;
            if (bad)
              state_q <= RESP;
            else if (req_we && req_size == SZ_W)
              state_q <= WRITE;
            else
              state_q <= READ;
          end
        end
        READ: begin
          // store: fold new lane into the old word; load: extract it
          if (we_q) begin
            wdata_q <= merged;
            state_q <= WRITE;
          end else begin
            rdata_q <= ext;
            state_q <= RESP;
          end
        end
        WRITE: state_q <= RESP;
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: word memory model, response/write scoreboard
// keyed by cycle, and directed vectors with literal expectations.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_rmw #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  always #5 clk = ~clk;

  // environment memory, with a side port for preloading
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [31:0] pl_a = '0;
  logic [31:0] pl_d = '0;

  assign mem_rd = mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[11:2]] <= mem_wd;
    else if (pl_en) mem[pl_a[11:2]] <= pl_d;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // model state
  logic [31:0] gold [0:1023];
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc = 0;
  int ready_at = 0;
  bit          exp_rv [int];
  logic [31:0] exp_rd [int];
  logic        exp_er [int];
  logic [31:0] exp_wa [int];
  logic [31:0] exp_wd [int];

  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic last_err = 1'b0;
  int we_cnt = 0;
  int last_we_cyc = 0;
  logic [31:0] last_wd = '0;

  task automatic model_accept();
    int a, lat, sh;
    logic [31:0] w, v, m, nw;
    bit e;
    a = cyc;
    w = gold[req_addr[11:2]];
    v = '0;
    e = (req_size == 2'b11) ||
        (req_size == 2'b01 && req_addr[0]) ||
        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    if (e) begin
      lat = 1;
    end else if (!req_we) begin
      lat = 2;
      if (req_size == 2'b00) begin
        sh = 8 * int'(req_addr[1:0]);
        v = (w >> sh) & 32'hFF;
        if (!req_unsigned && v[7]) v = v | 32'hFFFF_FF00;
      end else if (req_size == 2'b01) begin
        sh = 16 * int'(req_addr[1]);
        v = (w >> sh) & 32'hFFFF;
        if (!req_unsigned && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
    end else if (req_size == 2'b10) begin
      lat = 2;
      exp_wa[a] = {req_addr[31:2], 2'b00};
      exp_wd[a] = req_wdata;
    end else begin
      lat = 3;
      if (req_size == 2'b00) begin
        sh = 8 * int'(req_addr[1:0]);
        m = 32'hFF << sh;
      end else begin
        sh = 16 * int'(req_addr[1]);
        m = 32'hFFFF << sh;
      end
      nw = (w & ~m) | ((req_wdata << sh) & m);
      exp_wa[a + 1] = {req_addr[31:2], 2'b00};
      exp_wd[a + 1] = nw;
    end
    exp_rv[a + lat - 1] = 1'b1;
    exp_rd[a + lat - 1] = v;
    exp_er[a + lat - 1] = e;
    ready_at = a + lat;
    last_acc = a;
    acc_cnt++;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset && req_valid && req_ready) model_accept();
  end

  always @(posedge reset) begin
    exp_rv.delete();
    exp_rd.delete();
    exp_er.delete();
    exp_wa.delete();
    exp_wd.delete();
    ready_at = 0;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic [31:0] wa;
    if (!reset) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, cyc >= ready_at});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rv.exists(cyc)});
      if (exp_rv.exists(cyc)) begin
        chk("rsp_rdata", rsp_rdata, exp_rd[cyc]);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_er[cyc]});
        exp_rv.delete(cyc);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        last_rdata = rsp_rdata;
        last_err = rsp_err;
      end
      chk("mem_we", {31'b0, mem_we}, {31'b0, exp_wd.exists(cyc)});
      if (exp_wd.exists(cyc)) begin
        wa = exp_wa[cyc];
        chk("mem_a", mem_a, wa);
        chk("mem_wd", mem_wd, exp_wd[cyc]);
        gold[wa[11:2]] = exp_wd[cyc];
        exp_wd.delete(cyc);
        exp_wa.delete(cyc);
      end
      if (mem_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        last_wd = mem_wd;
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_a = a;
    pl_d = d;
    pl_en = 1'b1;
    gold[a[11:2]] = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, output int acc);
    int n0;
    n0 = acc_cnt;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n0) begin
        acc = last_acc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got none expected accept at %h", a);
      acc = cyc;
    end
    if (!hold) begin
      // scramble fields to show they were captured at accept
      req_valid = 1'b0;
      req_we = ~we;
      req_size = 2'b11;
      req_addr = 32'hFFFF_FFFF;
      req_wdata = 32'h5A5A_5A5A;
    end
  endtask

  task automatic wait_rsp(input int n0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp_cnt > n0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got none expected response");
    end
  endtask

  task automatic load_chk(input string n, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a,
                          input logic [31:0] exp);
    int acc, r0;
    r0 = rsp_cnt;
    do_req(1'b0, sz, uns, a, 32'h0, 1'b0, acc);
    wait_rsp(r0);
    chk(n, last_rdata, exp);
    chk({n, "_lat"}, last_rsp_cyc - acc + 1, 2);
  endtask

  initial begin
    int a, a2, r0, w0, bad;
    logic [31:0] ea [5];
    logic [1:0]  esz [3];
    logic [31:0] ead [3];
    bit          ewe [3];

    for (int i = 0; i < 1024; i++) gold[i] = '0;

    #2;
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", {31'b0, rsp_err}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // byte store RMW
    preload(32'h100, 32'h1122_3344);
    r0 = rsp_cnt;
    w0 = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, 1'b0, a);
    wait_rsp(r0);
    chk("sb_wd", last_wd, 32'h1122_AB44);
    chk("sb_we_cnt", we_cnt - w0, 1);
    chk("sb_we_lat", last_we_cyc - a + 1, 2);
    chk("sb_rsp_lat", last_rsp_cyc - a + 1, 3);
    chk("sb_err", {31'b0, last_err}, 0);
    chk("sb_rdata", last_rdata, 0);
    chk("sb_mem", mem[10'h40], 32'h1122_AB44);

    // byte loads
    preload(32'h100, 32'h80FF_0000);
    load_chk("lb_s", 2'b00, 1'b0, 32'h103, 32'hFFFF_FF80);
    load_chk("lb_u", 2'b00, 1'b1, 32'h103, 32'h0000_0080);
    load_chk("lb_s2", 2'b00, 1'b0, 32'h102, 32'hFFFF_FFFF);

    // halfword loads, word store/load
    preload(32'h200, 32'hBEEF_1234);
    load_chk("lh_u", 2'b01, 1'b1, 32'h202, 32'h0000_BEEF);
    load_chk("lh_s", 2'b01, 1'b0, 32'h200, 32'h0000_1234);
    load_chk("lh_s_neg", 2'b01, 1'b0, 32'h202, 32'hFFFF_BEEF);
    load_chk("lbu_1", 2'b00, 1'b1, 32'h201, 32'h0000_0012);
    r0 = rsp_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h204, 32'hCAFE_F00D, 1'b0, a);
    wait_rsp(r0);
    chk("sw_wd", last_wd, 32'hCAFE_F00D);
    chk("sw_we_lat", last_we_cyc - a + 1, 1);
    chk("sw_rsp_lat", last_rsp_cyc - a + 1, 2);
    chk("sw_mem", mem[10'h81], 32'hCAFE_F00D);
    load_chk("lw", 2'b10, 1'b0, 32'h204, 32'hCAFE_F00D);

    // halfword store into upper lane
    r0 = rsp_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFF_5566, 1'b0, a);
    wait_rsp(r0);
    chk("sh_wd", last_wd, 32'h5566_1234);

    // errors
    esz[0] = 2'b01; ead[0] = 32'h101; ewe[0] = 1'b0;
    esz[1] = 2'b10; ead[1] = 32'h102; ewe[1] = 1'b1;
    esz[2] = 2'b11; ead[2] = 32'h100; ewe[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r0 = rsp_cnt;
      w0 = we_cnt;
      do_req(ewe[i], esz[i], 1'b0, ead[i], 32'h1234_5678, 1'b0, a);
      wait_rsp(r0);
      chk("err_flag", {31'b0, last_err}, 1);
      chk("err_rdata", last_rdata, 0);
      chk("err_lat", last_rsp_cyc - a + 1, 1);
      chk("err_no_we", we_cnt - w0, 0);
    end

    // reset during READ of a byte store
    preload(32'h100, 32'h1122_3344);
    r0 = rsp_cnt;
    w0 = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_00EE, 1'b0, a);
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'b0, req_ready}, 1);
    chk("abort_mem_we", {31'b0, mem_we}, 0);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("abort_we_cnt", we_cnt - w0, 0);
    chk("abort_rsp_cnt", rsp_cnt - r0, 0);
    chk("abort_mem", mem[10'h40], 32'h1122_3344);
    @(posedge clk);
    #1;

    // back-to-back stores with req_valid held
    preload(32'h300, 32'hA0B0_C0D0);
    r0 = rsp_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h302, 32'h0000_0077, 1'b1, a);
    do_req(1'b1, 2'b10, 1'b0, 32'h304, 32'h1234_5678, 1'b0, a2);
    chk("b2b_gap", a2 - a, 4);
    wait_rsp(r0 + 1);
    chk("b2b_mem0", mem[10'hC0], 32'hA077_C0D0);
    chk("b2b_mem1", mem[10'hC1], 32'h1234_5678);

    repeat (4) @(negedge clk);
    ea[0] = 32'h100; ea[1] = 32'h200; ea[2] = 32'h204;
    ea[3] = 32'h300; ea[4] = 32'h304;
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (mem[ea[i][11:2]] !== gold[ea[i][11:2]]) bad++;
    chk("mem_vs_model", bad, 0);
    chk("model_drained", exp_rv.size() + exp_wd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the core datapath and the word-only data memory (word address = a[31:2], write on posedge clk, combinational read).
- Accepts byte/halfword/word load and store requests over a valid/ready handshake.
- Performs sub-word stores as a read-modify-write, because the data memory only writes full words.
- Sign- or zero-extends load data and flags misaligned or illegal-size requests without touching memory.

Parameters:
- AW, 32, request and memory address width.
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend when 1; ignored for stores.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  DW  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal size; valid with rsp_valid.
- mem_we  out  1  data memory write enable.
- mem_a  out  AW  data memory address, always {addr_q[AW-1:2],2'b00}.
- mem_wd  out  DW  data memory write data.
- mem_rd  in  DW  data memory read data (combinational from mem_a).

Behaviour:
- Reset values: state IDLE; addr_q, wdata_q, rdata_q, size_q, flags all 0. Outputs under reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a=0, mem_wd=0.
- Accept: a request is taken when req_valid && req_ready at posedge. All request fields are registered at that edge; later changes on req_* are ignored.
- Alignment check: half needs addr[0]=0; word needs addr[1:0]=00. size 11 is always an error.
- State IDLE, on accept:
  - error -> RESP with err_q=1.
  - load -> READ.
  - word store -> WRITE.
  - byte/half store -> READ.
- State READ: mem_a driven, mem_we=0.
  - Load: extract the lane selected by addr_q[1:0] from mem_rd, extend per req_unsigned, register into rdata_q; next state RESP.
  - Sub-word store: merge store data into mem_rd at the selected lane, register into wdata_q; next state WRITE.
  - Lane select: byte lane = addr[1:0]; half lane = addr[1] (bits 15:0 or 31:16).
- State WRITE: mem_we=1, mem_wd=wdata_q for exactly one cycle; next state RESP.
- State RESP: rsp_valid=1, rsp_rdata=rdata_q (0 for stores/errors), rsp_err=err_q; next state IDLE. rdata_q and err_q are cleared on return to IDLE.
- Latency from accept edge to rsp_valid cycle:
  - error: 1 cycle.
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
- Throughput: req_ready=0 in READ, WRITE and RESP. The next request can be accepted in the cycle after RESP.
- mem_we is decoded combinationally from state, so it is never high outside WRITE.
- Reset mid-operation: asserting reset in READ or WRITE forces IDLE asynchronously and drops mem_we in the same cycle. No partial or duplicate write occurs, and no response is issued for the aborted request.
- Errors never assert mem_we.
- Addresses wrap naturally within AW; no bounds check is performed.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_X=2'b11;
  - state enum {IDLE, READ, WRITE, RESP}.
- One combinational sub-module, subword_align, provides the lane merge (old word, new data, size, offset -> word) and the lane extract/extend (word, size, offset, unsigned -> data).
- The FSM and registers stay in lsu_rmw.

Test Plan:
- Sub-word store: mem[0x100]=0x11223344; store byte 0x000000AB at 0x101 -> one mem_we pulse 2 cycles after accept, mem_wd=0x1122AB44, rsp_valid 3 cycles after accept, rsp_err=0.
- Signed byte load: mem[0x100]=0x80FF0000; signed byte load at 0x103 -> rsp_rdata=0xFFFFFF80 2 cycles after accept. The same load with req_unsigned=1 -> 0x00000080.
- Halfword loads: mem[0x200]=0xBEEF1234; unsigned half load at 0x202 -> 0x0000BEEF; signed half load at 0x200 -> 0x00001234. Word store 0xCAFEF00D at 0x204 -> mem_wd=0xCAFEF00D, 2-cycle latency.
- Errors: half load at 0x101, word store at 0x102, and size=11 -> each gives rsp_err=1 with rsp_rdata=0, 1 cycle after accept, and mem_we never asserted.
- Reset mid-RMW: start a byte store, assert reset during READ -> req_ready=1, mem_we=0, rsp_valid=0 immediately; memory word unchanged.
- Back-to-back: hold req_valid high with two stores -> req_ready low until after RESP; the second store is accepted in the cycle after RESP and both writes land correctly.
